// File: rtl/cwd_pkg.sv
// Shared sizes, state type and row width for the codeword table loader.
package cwd_pkg;

    localparam int unsigned ANTS     = 32;
    localparam int unsigned WIDTH    = 32;
    localparam int unsigned DEPTH    = 64;
    localparam int unsigned ADDR_W   = 7;

    localparam int unsigned ROW_W    = WIDTH * ANTS;
    localparam int unsigned CWD_ROWS = 2 * DEPTH;
    // Beat counter spans 0..CWD_ROWS-1, one bit wider than the RAM address.
    localparam int unsigned BC_W     = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2
    } cwd_state_e;

endpackage

// File: rtl/cwd_xor_chk.sv
// Running XOR of accepted codeword rows, cleared when a new load is armed.
module cwd_xor_chk
    import cwd_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic [ROW_W-1:0] i_data,
    output logic [ROW_W-1:0] o_chk
);

    // Accumulate every accepted row; clear wins over accumulate.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            o_chk <= '0;
        end else if (i_en) begin
            o_chk <= o_chk ^ i_data;
        end
    end

endmodule

// File: rtl/code_word_load.sv
// Codeword table loader: streams 2*DEPTH rows (beam-interleaved even/odd)
// into the even/odd codeword RAM write ports and reports completion/errors.
// Optional macro CWD_LOAD_CHK_EN adds an XOR checksum compare at FLUSH.
module code_word_load
    import cwd_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [ROW_W-1:0]  s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
`ifdef CWD_LOAD_CHK_EN
    input  logic [ROW_W-1:0]  i_exp_chk,
`endif
    output logic              s_tready,
    output logic              o_wr_even_en,
    output logic              o_wr_odd_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [ROW_W-1:0]  o_wr_data,
    output logic              o_busy,
    output logic              o_load_done,
    output logic              o_err
);

    cwd_state_e        state_q, state_d;
    logic [BC_W-1:0]   bc_q, bc_d;
    logic              err_d, done_d, even_d, odd_d, busy_d, ready_d;
    logic [ADDR_W-1:0] addr_d;
    logic [ROW_W-1:0]  data_d;
    logic              beat_acc_c;
    logic              last_beat_c;

    assign beat_acc_c  = s_tvalid && s_tready;
    assign last_beat_c = (bc_q == BC_W'(CWD_ROWS - 1));

`ifdef CWD_LOAD_CHK_EN
    logic             chk_clr_c;
    logic [ROW_W-1:0] chk_sum;

    cwd_xor_chk u_xor_chk (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (chk_clr_c),
        .i_en    (beat_acc_c),
        .i_data  (s_tdata),
        .o_chk   (chk_sum)
    );
`endif

    // State, beat counter and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            bc_q         <= '0;
            s_tready     <= 1'b0;
            o_wr_even_en <= 1'b0;
            o_wr_odd_en  <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_busy       <= 1'b0;
            o_load_done  <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bc_q         <= bc_d;
            s_tready     <= ready_d;
            o_wr_even_en <= even_d;
            o_wr_odd_en  <= odd_d;
            o_wr_addr    <= addr_d;
            o_wr_data    <= data_d;
            o_busy       <= busy_d;
            o_load_done  <= done_d;
            o_err        <= err_d;
        end
    end

    // Next-state, beat bookkeeping and next output values.
    always_comb begin
        state_d = state_q;
        bc_d    = bc_q;
        err_d   = o_err;
        done_d  = 1'b0;
        even_d  = 1'b0;
        odd_d   = 1'b0;
        addr_d  = o_wr_addr;
        data_d  = o_wr_data;
`ifdef CWD_LOAD_CHK_EN
        chk_clr_c = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    err_d   = 1'b0;
                    bc_d    = '0;
                    state_d = LOAD;
`ifdef CWD_LOAD_CHK_EN
                    chk_clr_c = 1'b1;
`endif
                end
            end
            LOAD: begin
                if (beat_acc_c) begin
                    // Even/odd bank from beat parity, beam index from beat/2.
                    even_d = ~bc_q[0];
                    odd_d  = bc_q[0];
                    addr_d = ADDR_W'(bc_q >> 1);
                    data_d = s_tdata;
                    bc_d   = bc_q + BC_W'(1);
                    if (s_tlast && last_beat_c) begin
                        state_d = FLUSH;
                    end else if (s_tlast || last_beat_c) begin
                        // Framing error: the offending beat is still written.
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            FLUSH: begin
                state_d = IDLE;
`ifdef CWD_LOAD_CHK_EN
                if (chk_sum != i_exp_chk) begin
                    err_d = 1'b1;
                end else begin
                    done_d = 1'b1;
                end
`else
                done_d = 1'b1;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == LOAD);
    end

endmodule

// File: doc/code_word_load.md
Name: code_word_load

Overview:
- Writer side of the codeword store. Accepts a streamed codeword table over a valid/ready interface and writes each row into the even or odd codeword RAM through registered write ports.
- Lets the beam-codeword reader fetch a run-time-loaded table instead of a fixed ROM image.
- Sits between the control/DMA stream and the two codeword RAMs. It reports completion and framing errors to control.

Parameters:
- ANTS, 32, antennas per codeword row.
- WIDTH, 32, bits per antenna weight (packed IQ).
- DEPTH, 64, beams per table. Each bank holds DEPTH rows.
- ADDR_W, 7, RAM address width. Must satisfy 2^ADDR_W >= DEPTH.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  pulse. Arms a table load. Ignored unless the FSM is in IDLE.
- s_tdata  in  WIDTH*ANTS  codeword row.
- s_tvalid  in  1  row valid.
- s_tlast  in  1  marks the final row of the table.
- s_tready  out  1  row accepted when s_tvalid && s_tready.
- o_wr_even_en  out  1  write strobe, even RAM.
- o_wr_odd_en  out  1  write strobe, odd RAM.
- o_wr_addr  out  ADDR_W  beam index.
- o_wr_data  out  WIDTH*ANTS  row data.
- o_busy  out  1  high in LOAD and FLUSH.
- o_load_done  out  1  one-cycle pulse on successful completion.
- o_err  out  1  sticky framing error. Cleared by i_start or i_reset.

Behaviour:
- Reset values:
  - All outputs 0. s_tready=0.
  - FSM=IDLE. Beat counter=0.
- Row order on the stream: beam0 even, beam0 odd, beam1 even, and so on. Total 2*DEPTH beats.
  - Beat counter bc ranges 0..2*DEPTH-1.
  - Bank = bc[0]: 0 selects even, 1 selects odd.
  - Address = bc >> 1.
- FSM states:
  - IDLE: s_tready=0. On i_start, clear o_err and bc, then go to LOAD.
  - LOAD: s_tready=1. On each accepted beat, register data, address and bank strobe (exactly one of even_en/odd_en). bc increments.
    - Beat with bc==2*DEPTH-1 and s_tlast=1: go to FLUSH.
    - Beat with s_tlast=1 and bc<2*DEPTH-1 (early last): set o_err, go to IDLE. That beat IS still written.
    - Beat with bc==2*DEPTH-1 and s_tlast=0 (missing last): set o_err, go to IDLE. That beat is written.
  - FLUSH: one cycle. s_tready=0. The final write drains. Pulse o_load_done, then go to IDLE.
- Latency: accepted beat at cycle N produces a write strobe at cycle N+1. Strobes are one cycle wide per beat.
- Gaps: s_tvalid=0 in LOAD produces no strobe; bc holds.
- s_tready is a registered function of state only. It does not depend on s_tvalid.
- i_start while busy: ignored, no effect on bc.
- i_start in the same cycle as a completing FLUSH: ignored. A new i_start is needed in IDLE.
- Reset mid-load:
  - Outputs return to reset values the next cycle. No further strobes.
  - Partial RAM contents are undefined to consumers. o_load_done is never asserted for an aborted load.
- Beats presented in IDLE are not accepted, since s_tready=0.

Optional Feature:
- Macro: CWD_LOAD_CHK_EN.
- With the macro:
  - Extra input i_exp_chk [WIDTH*ANTS-1:0].
  - Running XOR of all accepted rows, cleared on i_start.
  - At FLUSH, a mismatch against i_exp_chk sets o_err and suppresses o_load_done.
- Without the macro: no port, no checksum, no compare. Timing and behaviour are otherwise identical.

Decomposition:
- Shared package cwd_pkg holds:
  - the state enum {IDLE, LOAD, FLUSH};
  - CWD_ROWS = 2*DEPTH;
  - the row-width localparam ROW_W = WIDTH*ANTS.
- One sub-module is natural: cwd_xor_chk, the checksum accumulator, instantiated only under CWD_LOAD_CHK_EN.

Test Plan:
- Full table, back-to-back beats, row k = k replicated:
  - 128 strobes, alternating even/odd; addr 0,0,1,1,...,63,63.
  - Final strobe: odd_en, addr 63.
  - o_load_done one cycle after it; o_err=0.
- Random s_tvalid gaps, ~30% idle:
  - Same 128 writes in the same order.
  - No strobe in any idle cycle.
  - o_load_done still one cycle after the final write.
- s_tlast on beat 10:
  - Beat 10 written (even, addr 5).
  - o_err=1; FSM in IDLE; s_tready=0; no o_load_done.
- No s_tlast on beat 127:
  - o_err=1; no o_load_done.
  - Next i_start clears o_err, and a clean load succeeds.
- i_reset asserted at beat 40:
  - The next cycle has all strobes and s_tready at 0.
  - A following i_start plus full table completes normally.
- With CWD_LOAD_CHK_EN:
  - Correct i_exp_chk gives o_load_done.
  - Flipping one bit of i_exp_chk gives o_err=1 and no o_load_done.
